// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a handshaked data-memory port for loads/stores,
// aligns store data, extracts/extends load data and flags misaligned accesses.
module mem_stage #(
  parameter int IN_W  = 158,
  parameter int OUT_W = 122
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             MEM_valid,
  input  logic [IN_W-1:0]  EXE_MEM_bus_r,
  input  logic             next_allowin,
  input  logic             cancel,
  output logic             MEM_over,
  output logic [OUT_W-1:0] MEM_WB_bus,
  output logic [4:0]       MEM_wdest,
  output logic [31:0]      MEM_pc,
  output logic             dm_req,
  output logic [3:0]       dm_wen,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  input  logic             dm_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [5:0]  mem_control;
  logic [31:0] store_data;
  logic [31:0] exe_result;
  logic [31:0] lo_result;
  logic [5:0]  hilo_cp0_flags;
  logic [7:0]  cp0r_addr;
  logic        syscall;
  logic        eret;
  logic        rf_wen;
  logic [4:0]  rf_wdest;
  logic [31:0] pc;
  logic        brk;
  logic        ov;

  assign {mem_control, store_data, exe_result, lo_result, hilo_cp0_flags, cp0r_addr,
          syscall, eret, rf_wen, rf_wdest, pc, brk, ov} = EXE_MEM_bus_r;

  // mem_control[0] is reserved and intentionally has no effect
  logic unused_reserved;
  assign unused_reserved = mem_control[0];

  logic       is_load;
  logic       is_store;
  logic [1:0] mem_size;
  logic       sign_ext;
  logic       mem_op;
  logic       misal;
  logic       mem_access;
  logic       adel;
  logic       ades;
  logic       rf_wen_o;

  assign is_load  = mem_control[5];
  assign is_store = mem_control[4];
  assign mem_size = mem_control[3:2];
  assign sign_ext = mem_control[1];
  assign mem_op   = is_load | is_store;

  always_comb begin
    misal = 1'b0;
    case (mem_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = exe_result[0];
      default: misal = |exe_result[1:0];
    endcase
  end

  assign mem_access = mem_op & ~misal;
  assign adel       = MEM_valid & is_load & misal;
  assign ades       = MEM_valid & is_store & misal;
  assign rf_wen_o   = rf_wen & ~adel;

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    MEM_over = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_valid & mem_access & ~cancel) begin
          state_d = REQ;
        end else begin
          MEM_over = MEM_valid & ~cancel;
        end
      end
      REQ: begin
        if (dm_ack) begin
          rdata_d = dm_rdata;
          state_d = cancel ? IDLE : DONE;
        end else if (cancel) begin
          state_d = ABORT;
        end
      end
      DONE: begin
        MEM_over = MEM_valid & ~cancel;
        if (cancel | next_allowin) begin
          state_d = IDLE;
        end
      end
      ABORT: begin
        // an issued request must run to its ack even after a flush
        if (dm_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm_req  = (state_q == REQ) | (state_q == ABORT);
  assign dm_addr = {exe_result[31:2], 2'b00};

  always_comb begin
    dm_wen   = 4'b0000;
    dm_wdata = store_data;
    case (mem_size)
      2'b00:   dm_wdata = {4{store_data[7:0]}};
      2'b01:   dm_wdata = {2{store_data[15:0]}};
      default: dm_wdata = store_data;
    endcase
    if (is_store & ~misal) begin
      case (mem_size)
        2'b00:   dm_wen = 4'b0001 << exe_result[1:0];
        2'b01:   dm_wen = exe_result[1] ? 4'b1100 : 4'b0011;
        default: dm_wen = 4'b1111;
      endcase
    end
  end

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] mem_result;

  always_comb begin
    load_byte = rdata_q[{exe_result[1:0], 3'b000} +: 8];
    load_half = exe_result[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mem_size)
      2'b00:   load_data = {{24{sign_ext & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{sign_ext & load_half[15]}}, load_half};
      default: load_data = rdata_q;
    endcase
    // misaligned accesses forward the bad virtual address instead of load data
    mem_result = (is_load & ~misal) ? load_data : exe_result;
  end

  assign MEM_WB_bus = {mem_result, lo_result, hilo_cp0_flags, cp0r_addr, syscall, eret,
                       rf_wen_o, rf_wdest, pc, brk, ov, adel, ades};
  assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
  assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a scoreboard queue holds the expected writeback
// bus for each issued instruction and is compared when the stage reports MEM_over.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         MEM_valid = 1'b0;
  logic [157:0] EXE_MEM_bus_r = '0;
  logic         next_allowin = 1'b1;
  logic         cancel = 1'b0;
  logic [31:0]  dm_rdata = 32'd0;
  logic         dm_ack = 1'b0;
  logic         MEM_over;
  logic [121:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_pc;
  logic         dm_req;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;

  mem_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .MEM_valid    (MEM_valid),
    .EXE_MEM_bus_r(EXE_MEM_bus_r),
    .next_allowin (next_allowin),
    .cancel       (cancel),
    .MEM_over     (MEM_over),
    .MEM_WB_bus   (MEM_WB_bus),
    .MEM_wdest    (MEM_wdest),
    .MEM_pc       (MEM_pc),
    .dm_req       (dm_req),
    .dm_wen       (dm_wen),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [121:0] sb_q[$];

  logic [5:0]   cur_ctl;
  logic [31:0]  cur_addr, cur_sdata, cur_lo, cur_pc;
  logic [5:0]   cur_flags;
  logic [7:0]   cur_cp0;
  logic [1:0]   cur_se, cur_bo;
  logic         cur_rfw;
  logic [4:0]   cur_dest;

  logic [31:0]  last_result, last_wdata, last_addr;
  logic [3:0]   last_wen;
  logic [121:0] last_bus;
  int           last_req_cycles;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic driveBus(input logic [5:0] ctl, input logic [31:0] addr, sdata,
                          input logic rfw);
    cur_ctl   = ctl;
    cur_addr  = addr;
    cur_sdata = sdata;
    cur_rfw   = rfw;
    cur_lo    = $urandom;
    cur_pc    = $urandom;
    cur_flags = 6'($urandom_range(0, 63));
    cur_cp0   = 8'($urandom_range(0, 255));
    cur_se    = 2'($urandom_range(0, 3));
    cur_bo    = 2'($urandom_range(0, 3));
    cur_dest  = 5'($urandom_range(1, 31));
    EXE_MEM_bus_r = {ctl, sdata, addr, cur_lo, cur_flags, cur_cp0, cur_se, rfw,
                     cur_dest, cur_pc, cur_bo};
  endtask

  function automatic logic modelMisal(input logic [5:0] ctl, input logic [31:0] addr);
    if (ctl[3:2] == 2'b00) return 1'b0;
    if (ctl[3:2] == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] ctl, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr[1:0])
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    if (ctl[3:2] == 2'b00) return ctl[1] ? {{24{b[7]}}, b} : {24'd0, b};
    if (ctl[3:2] == 2'b01) return ctl[1] ? {{16{h[15]}}, h} : {16'd0, h};
    return rdata;
  endfunction

  function automatic logic [121:0] modelBus(input logic [31:0] rdata);
    logic mis, adel, ades;
    logic [31:0] res;
    mis  = modelMisal(cur_ctl, cur_addr);
    adel = cur_ctl[5] & mis;
    ades = cur_ctl[4] & mis;
    res  = (cur_ctl[5] && !mis) ? modelLoad(cur_ctl, cur_addr, rdata) : cur_addr;
    return {res, cur_lo, cur_flags, cur_cp0, cur_se, cur_rfw & ~adel, cur_dest, cur_pc,
            cur_bo, adel, ades};
  endfunction

  function automatic logic [3:0] modelWen(input logic [5:0] ctl, input logic [31:0] addr);
    if (!ctl[4] || modelMisal(ctl, addr)) return 4'b0000;
    if (ctl[3:2] == 2'b00) return 4'b0001 << addr[1:0];
    if (ctl[3:2] == 2'b01) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [5:0] ctl, input logic [31:0] sd);
    if (ctl[3:2] == 2'b00) return {4{sd[7:0]}};
    if (ctl[3:2] == 2'b01) return {2{sd[15:0]}};
    return sd;
  endfunction

  // Issues one instruction, plays the memory side with the given wait states and
  // keeps writeback stalled for 'hold' extra cycles once the result is ready.
  task automatic applyStimulus(input logic [5:0] ctl, input logic [31:0] addr, sdata,
                               input logic rfw, input logic [31:0] rdata,
                               input int wait_cyc, input int hold);
    logic [121:0] exp;
    logic memop;
    step();
    driveBus(ctl, addr, sdata, rfw);
    MEM_valid    = 1'b1;
    cancel       = 1'b0;
    dm_ack       = 1'b0;
    next_allowin = (hold == 0);
    sb_q.push_back(modelBus(rdata));
    memop = (ctl[5] | ctl[4]) & ~modelMisal(ctl, addr);
    #1;
    checkOutput("entry_req", dm_req, 1'b0);
    checkOutput("wdest", MEM_wdest, cur_dest);
    checkOutput("pc", MEM_pc, cur_pc);
    last_req_cycles = 0;
    last_wen = dm_wen;
    if (memop) begin
      checkOutput("entry_over", MEM_over, 1'b0);
      for (int w = 0; w <= wait_cyc; w++) begin
        step();
        dm_ack   = (w == wait_cyc);
        dm_rdata = (w == wait_cyc) ? rdata : $urandom;
        #1;
        if (dm_req) last_req_cycles++;
        checkOutput("req_held", dm_req, 1'b1);
        checkOutput("req_over", MEM_over, 1'b0);
        checkOutput("dm_wen", dm_wen, modelWen(ctl, addr));
        checkOutput("dm_addr", dm_addr, {addr[31:2], 2'b00});
        if (ctl[4]) checkOutput("dm_wdata", dm_wdata, modelWdata(ctl, sdata));
        last_wen   = dm_wen;
        last_wdata = dm_wdata;
        last_addr  = dm_addr;
      end
      step();
      dm_ack   = 1'b0;
      dm_rdata = $urandom;
      #1;
      checkOutput("done_req", dm_req, 1'b0);
    end else begin
      checkOutput("pass_wen", dm_wen, 4'b0000);
    end
    checkOutput("over", MEM_over, 1'b1);
    exp = sb_q.pop_front();
    checkOutput("wb_bus", MEM_WB_bus, exp);
    last_bus    = MEM_WB_bus;
    last_result = MEM_WB_bus[121:90];
    for (int h = 0; h < hold; h++) begin
      step();
      dm_rdata = $urandom;
      #1;
      checkOutput("hold_over", MEM_over, 1'b1);
      checkOutput("hold_bus", MEM_WB_bus, exp);
    end
    next_allowin = 1'b1;
    step();
    MEM_valid = 1'b0;
    #1;
    checkOutput("exit_req", dm_req, 1'b0);
    checkOutput("exit_over", MEM_over, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0]  rctl;
    logic [31:0] raddr;
    int          kind;

    #13;
    checkOutput("reset_req", dm_req, 1'b0);
    checkOutput("reset_over", MEM_over, 1'b0);
    checkOutput("reset_wdest", MEM_wdest, 5'd0);
    resetn = 1'b1;

    applyStimulus(6'b000000, 32'h0000_1234, 32'h0, 1'b1, 32'h0, 0, 0);
    checkOutput("alu_result", last_result, 32'h0000_1234);

    applyStimulus(6'b100010, 32'h0000_1003, 32'h0, 1'b1, 32'h80FF_0000, 0, 0);
    checkOutput("lb_s_result", last_result, 32'hFFFF_FF80);
    checkOutput("lb_addr", last_addr, 32'h0000_1000);
    checkOutput("lb_wen", last_wen, 4'b0000);
    applyStimulus(6'b100000, 32'h0000_1003, 32'h0, 1'b1, 32'h80FF_0000, 0, 0);
    checkOutput("lb_u_result", last_result, 32'h0000_0080);

    applyStimulus(6'b010100, 32'h0000_0022, 32'hABCD_5678, 1'b0, 32'h0, 3, 0);
    checkOutput("sh_req_cycles", last_req_cycles, 4);
    checkOutput("sh_wen", last_wen, 4'b1100);
    checkOutput("sh_wdata", last_wdata, 32'h5678_5678);

    applyStimulus(6'b101000, 32'h0000_0006, 32'h0, 1'b1, 32'h0, 0, 0);
    checkOutput("lw_mis_adel", last_bus[1], 1'b1);
    checkOutput("lw_mis_rfwen", last_bus[41], 1'b0);
    checkOutput("lw_mis_result", last_result, 32'h0000_0006);
    applyStimulus(6'b011000, 32'h0000_0005, 32'h1357_9BDF, 1'b0, 32'h0, 0, 0);
    checkOutput("sw_mis_ades", last_bus[0], 1'b1);

    applyStimulus(6'b100100, 32'h0000_0002, 32'h0, 1'b1, 32'h8765_4321, 1, 3);
    checkOutput("lhu_result", last_result, 32'h0000_8765);
    applyStimulus(6'b100110, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_F00F, 0, 0);
    checkOutput("lh_s_result", last_result, 32'hFFFF_F00F);
    applyStimulus(6'b101100, 32'h0000_0040, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, 0);
    checkOutput("lw_sz3_result", last_result, 32'hDEAD_BEEF);
    applyStimulus(6'b010000, 32'h0000_0001, 32'h0000_00A5, 1'b0, 32'h0, 0, 0);
    checkOutput("sb_wen", last_wen, 4'b0010);
    checkOutput("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    // cancel while waiting: request stays up until the ack, no result produced
    step();
    driveBus(6'b101000, 32'h0000_0100, 32'h0, 1'b1);
    MEM_valid = 1'b1;
    next_allowin = 1'b1;
    #1;
    checkOutput("abort_entry_over", MEM_over, 1'b0);
    step(); cancel = 1'b1; #1;
    checkOutput("abort_req0", dm_req, 1'b1);
    checkOutput("abort_over0", MEM_over, 1'b0);
    step(); #1;
    checkOutput("abort_req1", dm_req, 1'b1);
    checkOutput("abort_over1", MEM_over, 1'b0);
    step(); cancel = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h5555_AAAA; #1;
    checkOutput("abort_req2", dm_req, 1'b1);
    checkOutput("abort_over2", MEM_over, 1'b0);
    step(); dm_ack = 1'b0; MEM_valid = 1'b0; #1;
    checkOutput("abort_idle_req", dm_req, 1'b0);
    checkOutput("abort_idle_over", MEM_over, 1'b0);

    // cancel together with the ack goes straight back to IDLE
    step();
    driveBus(6'b100000, 32'h0000_0104, 32'h0, 1'b1);
    MEM_valid = 1'b1;
    #1;
    step(); cancel = 1'b1; dm_ack = 1'b1; #1;
    checkOutput("cack_req", dm_req, 1'b1);
    step(); cancel = 1'b0; dm_ack = 1'b0; MEM_valid = 1'b0; #1;
    checkOutput("cack_after_req", dm_req, 1'b0);
    checkOutput("cack_after_over", MEM_over, 1'b0);

    // cancel in DONE suppresses MEM_over; the held load then restarts from IDLE
    step();
    driveBus(6'b101000, 32'h0000_0200, 32'h0, 1'b1);
    MEM_valid = 1'b1;
    next_allowin = 1'b0;
    #1;
    step(); dm_ack = 1'b1; dm_rdata = 32'h1111_2222; #1;
    checkOutput("dcan_req", dm_req, 1'b1);
    step(); dm_ack = 1'b0; cancel = 1'b1; #1;
    checkOutput("dcan_over", MEM_over, 1'b0);
    step(); cancel = 1'b0; #1;
    checkOutput("dcan_idle_over", MEM_over, 1'b0);
    checkOutput("dcan_idle_req", dm_req, 1'b0);
    step(); dm_ack = 1'b1; dm_rdata = 32'h3333_4444; #1;
    checkOutput("dcan_rereq", dm_req, 1'b1);
    step(); dm_ack = 1'b0; next_allowin = 1'b1; #1;
    checkOutput("dcan_reover", MEM_over, 1'b1);
    checkOutput("dcan_result", MEM_WB_bus[121:90], 32'h3333_4444);
    step(); MEM_valid = 1'b0; #1;
    checkOutput("dcan_exit_req", dm_req, 1'b0);

    // stray ack while idle has no effect
    step(); dm_ack = 1'b1; #1;
    step(); dm_ack = 1'b0; #1;
    checkOutput("stray_ack_req", dm_req, 1'b0);
    checkOutput("stray_ack_over", MEM_over, 1'b0);

    // asynchronous reset in the middle of a request
    step();
    driveBus(6'b101000, 32'h0000_0080, 32'h0, 1'b1);
    MEM_valid = 1'b1;
    #1;
    step(); #1;
    checkOutput("rst_pre_req", dm_req, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("rst_async_req", dm_req, 1'b0);
    checkOutput("rst_async_over", MEM_over, 1'b0);
    #1;
    resetn = 1'b1;
    MEM_valid = 1'b0;
    step(); #1;
    checkOutput("rst_idle_req", dm_req, 1'b0);
    applyStimulus(6'b000000, 32'h0000_0ABC, 32'h0, 1'b1, 32'h0, 0, 0);
    checkOutput("rst_alu_result", last_result, 32'h0000_0ABC);

    for (int i = 0; i < 12; i++) begin
      kind  = $urandom_range(0, 2);
      rctl  = 6'($urandom_range(0, 15));
      raddr = $urandom;
      if (kind == 1) rctl = rctl | 6'b100000;
      if (kind == 2) rctl = rctl | 6'b010000;
      applyStimulus(rctl, raddr, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
